seg_kulisch_acc: RTL and testbench
==================================

// Module: seg_kulisch_acc
// PURPOSE
//  Parametrised segmented exact (Kulisch-style) accumulator; successor to the fixed 5-segment dot-product accumulator.
//  Sums a run-time-programmable number of aligned signed mantissa terms with deferred per-segment carries.
//  Emits the resolved two's-complement sum over a valid/ready handshake.
//  Sits after the multiplier/decode stage; results feed the output rounding/encode stage.
// PARAMETERS
//  MW    10  magnitude width of incoming product mantissa
//  SEG   24  bits per accumulator segment
//  NSEG  4   number of segments (>=2)
//  HEAD  6   signed guard/head bits above the segments
//  KMAX  64  maximum terms per run
//  Derived: W=HEAD+NSEG*SEG total accumulator width; POSW=$clog2(NSEG*SEG+HEAD); KW=$clog2(KMAX+1)
// PORTS
//  clk_i    in   1        clock
//  rstn     in   1        asynchronous active-low reset
//  start    in   1        begin run; sampled only in IDLE
//  cfg_k    in   KW       terms in run; latched on start; values >KMAX saturate to KMAX
//  in_vld   in   1        term valid
//  in_rdy   out  1        term ready
//  in_sign  in   1        term sign (1 = negative)
//  in_zero  in   1        term is zero (counted, adds nothing)
//  in_pos   in   POSW     bit position of in_mts LSB within accumulator
//  in_mts   in   MW       unsigned term magnitude
//  out_vld  out  1        result valid
//  out_rdy  in   1        result ready
//  out_acc  out  W        resolved signed sum {head, seg[NSEG-1..0]}
//  out_ovf  out  1        sticky: range or head overflow during run
//  busy     out  1        high in any state but IDLE
// BEHAVIOUR
//  Reset (any time, incl. mid-run): state=IDLE; all segments, head, count, ovf = 0; in_rdy=out_vld=busy=0; out_acc=0.
//  FSM IDLE -> ACC on start (cfg_k!=0); IDLE -> FLUSH on start with cfg_k==0; start ignored elsewhere.
//   On start: segments/head/count/ovf cleared, k latched.
//  ACC: in_rdy=1. Term accepted when in_vld & in_rdy; count++.
//   Accepting the k-th term -> FLUSH next cycle.
//  Term alignment:
//   - v = (-1)^in_sign * in_mts << in_pos, as a W-bit two's complement value.
//   - Slice i = v[i*SEG +: SEG]; head slice = v[W-1 -: HEAD].
//   - in_zero or in_mts==0 -> v=0.
//  Range check: in_pos+MW > W-1 -> term dropped (still counted), out_ovf set.
//  Segment storage is SEG+1 bits; bit SEG is the pending carry. Update applies every ACC/FLUSH cycle:
//   - seg0 <= {1'b0,seg0[SEG-1:0]} + slice0
//   - seg_i <= {1'b0,seg_i[SEG-1:0]} + seg_{i-1}[SEG] + slice_i   (fits: max 2^(SEG+1)-1)
//   - head <= head + seg_{NSEG-1}[SEG] + headslice, modulo 2^HEAD
//   - Signed overflow of the head add sets out_ovf.
//   - In ACC cycles with no accepted term, all slices are 0 (carries still ripple).
//  FLUSH: in_rdy=0; slices 0. Runs exactly NSEG cycles, then -> OUT. All carry bits are 0 on exit.
//  OUT: out_vld=1; out_acc = {head, seg_i[SEG-1:0]} held stable until out_vld & out_rdy.
//   Handshake -> IDLE, out_vld drops the next cycle. out_ovf held with out_acc; cleared only on start/reset.
//  Latency: last accept at cycle t -> out_vld high from cycle t+NSEG+1.
//   cfg_k==0: out_vld at start+NSEG+1, out_acc=0.
//  Throughput: 1 term/cycle in ACC; back-to-back runs need start in IDLE.
//   Min gap is NSEG+2 cycles plus the out handshake.
//  Result is exact mod 2^W. Sum is correct whenever out_ovf=0.
// TESTING
//  T1 MW=10,SEG=24,NSEG=4: k=3, terms +1023@0, +1@0, -1@0.
//     -> out_acc=1023, out_ovf=0, out_vld at last_accept+5.
//  T2 carry ripple: k=2, +1023@14, +1023@14 (crosses seg0/seg1).
//     -> out_acc=2046<<14, seg0[SEG] carry resolved in FLUSH.
//  T3 negative across all segments: k=1, -1@0.
//     -> out_acc=all ones (W bits), out_ovf=0.
//  T4 range: k=2, +5@(W-MW), +3@0.
//     -> out_acc=3, out_ovf=1; head overflow: 33 terms of +1023@(W-MW-1) -> out_ovf=1.
//  T5 handshake/boundaries:
//     - in_vld gaps and out_rdy held low 7 cycles -> out_acc stable, no extra terms accepted.
//     - start during ACC ignored.
//     - cfg_k=0 -> out_acc=0.
//     - cfg_k=KMAX+5 -> exactly KMAX terms accepted.
//  T6 rstn low mid-ACC after 2 of 4 terms -> all outputs 0, IDLE.
//     New run k=1 +7@3 -> out_acc=56.

Source files
------------

// File: rtl/seg_kulisch_acc.sv
// Segmented exact accumulator: aligned signed terms are added into SEG-bit
// segments that each keep one pending carry bit. Carries move up one segment
// per cycle and are fully resolved by NSEG flush cycles before the result is
// presented on a valid/ready handshake.

// One accumulator segment: SEG data bits plus a pending carry in bit SEG.
module seg_kulisch_seg #(
  parameter int SEG = 24
) (
  input  logic           clk_i,
  input  logic           rstn,
  input  logic           clr,
  input  logic           en,
  input  logic           cin,
  input  logic [SEG-1:0] slice,
  output logic [SEG:0]   seg
);

  // Fold last cycle's carry out away, add the carry from below and this slice.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)     seg <= '0;
    else if (clr)  seg <= '0;
    else if (en)   seg <= {1'b0, seg[SEG-1:0]} + {{SEG{1'b0}}, cin} + {1'b0, slice};
  end

endmodule

module seg_kulisch_acc #(
  parameter  int MW   = 10,
  parameter  int SEG  = 24,
  parameter  int NSEG = 4,
  parameter  int HEAD = 6,
  parameter  int KMAX = 64,
  localparam int W    = HEAD + NSEG*SEG,
  localparam int POSW = $clog2(NSEG*SEG + HEAD),
  localparam int KW   = $clog2(KMAX + 1)
) (
  input  logic            clk_i,
  input  logic            rstn,
  input  logic            start,
  input  logic [KW-1:0]   cfg_k,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic            in_sign,
  input  logic            in_zero,
  input  logic [POSW-1:0] in_pos,
  input  logic [MW-1:0]   in_mts,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [W-1:0]    out_acc,
  output logic            out_ovf,
  output logic            busy
);

  localparam int FW = $clog2(NSEG + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FLUSH, S_OUT} state_t;

  state_t state_q, state_d;
  logic [KW-1:0] k_q, cnt_q, k_sat;
  logic [FW-1:0] fcnt_q;
  logic [HEAD-1:0] head_q;
  logic ovf_q;

  logic clr, upd, take, drop, last_term;
  logic [W-1:0] mag, v;
  logic [NSEG-1:0][SEG-1:0] slice;
  logic [NSEG-1:0][SEG:0]   seg_q;
  logic [NSEG:0]            cy;
  logic [HEAD-1:0]          hs;
  logic signed [HEAD:0]     hsum;
  logic                     hovf;
  logic [NSEG*SEG-1:0]      low;

  assign k_sat     = (int'(cfg_k) > KMAX) ? KW'(KMAX) : cfg_k;
  assign upd       = (state_q == S_ACC) || (state_q == S_FLUSH);
  assign take      = (state_q == S_ACC) && in_vld;
  assign last_term = take && ((cnt_q + KW'(1)) == k_q);

  // Terms whose top bit would reach the sign bit are dropped but still counted.
  assign drop = (int'(in_pos) + MW) > (W - 1);
  assign mag  = W'(in_mts) << in_pos;
  assign v    = (take && !in_zero && !drop) ? (in_sign ? ({W{1'b0}} - mag) : mag) : '0;
  assign hs   = v[W-1 -: HEAD];

  assign cy[0] = 1'b0;

  for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
    assign slice[gi]             = v[gi*SEG +: SEG];
    assign cy[gi+1]              = seg_q[gi][SEG];
    assign low[gi*SEG +: SEG]    = seg_q[gi][SEG-1:0];
    seg_kulisch_seg #(.SEG(SEG)) u_seg (
      .clk_i (clk_i),
      .rstn  (rstn),
      .clr   (clr),
      .en    (upd),
      .cin   (cy[gi]),
      .slice (slice[gi]),
      .seg   (seg_q[gi])
    );
  end

  // Head add is done one bit wider so signed overflow shows as top-bit disagreement.
  assign hsum = $signed({head_q[HEAD-1], head_q}) + $signed({hs[HEAD-1], hs})
              + $signed({{HEAD{1'b0}}, cy[NSEG]});
  assign hovf = hsum[HEAD] ^ hsum[HEAD-1];

  assign out_acc = {head_q, low};
  assign out_ovf = ovf_q;
  assign busy    = (state_q != S_IDLE);

  // State register.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) begin
        clr     = 1'b1;
        state_d = (k_sat == '0) ? S_FLUSH : S_ACC;
      end
      S_ACC: begin
        in_rdy = 1'b1;
        if (last_term) state_d = S_FLUSH;
      end
      S_FLUSH: if (fcnt_q == FW'(NSEG - 1)) state_d = S_OUT;
      S_OUT: begin
        out_vld = 1'b1;
        if (out_rdy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Run length and accepted-term count.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn) begin
      k_q   <= '0;
      cnt_q <= '0;
    end else if (clr) begin
      k_q   <= k_sat;
      cnt_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + KW'(1);
    end
  end

  // Flush cycle counter, idle at zero outside FLUSH.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)                  fcnt_q <= '0;
    else if (state_q != S_FLUSH) fcnt_q <= '0;
    else                        fcnt_q <= fcnt_q + FW'(1);
  end

  // Signed head: absorbs the top segment carry and the head slice.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)     head_q <= '0;
    else if (clr)  head_q <= '0;
    else if (upd)  head_q <= hsum[HEAD-1:0];
  end

  // Sticky overflow: dropped out-of-range term or head wrap.
  always_ff @(posedge clk_i or negedge rstn) begin
    if (!rstn)                             ovf_q <= 1'b0;
    else if (clr)                          ovf_q <= 1'b0;
    else if ((take && drop) || (upd && hovf)) ovf_q <= 1'b1;
  end

endmodule

// File: tb/tb_seg_kulisch_acc.sv
// Bench for seg_kulisch_acc: directed vector table, hand-written handshake and
// reset sequences, and random runs against an exact-integer sum model.
module tb_seg_kulisch_acc;

  localparam int MW = 10, SEG = 24, NSEG = 4, HEAD = 6, KMAX = 64;
  localparam int W = HEAD + NSEG*SEG;
  localparam int POSW = $clog2(NSEG*SEG + HEAD);
  localparam int KW = $clog2(KMAX + 1);
  localparam int MAXPOS = W - 1 - MW;

  logic clk_i = 1'b0, rstn = 1'b0;
  logic start = 1'b0, in_vld = 1'b0, in_sign = 1'b0, in_zero = 1'b0, out_rdy = 1'b0;
  logic [KW-1:0] cfg_k = '0;
  logic [POSW-1:0] in_pos = '0;
  logic [MW-1:0] in_mts = '0;
  logic in_rdy, out_vld, out_ovf, busy;
  logic [W-1:0] out_acc;

  seg_kulisch_acc #(.MW(MW), .SEG(SEG), .NSEG(NSEG), .HEAD(HEAD), .KMAX(KMAX)) dut (
    .clk_i(clk_i), .rstn(rstn), .start(start), .cfg_k(cfg_k),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_sign(in_sign), .in_zero(in_zero),
    .in_pos(in_pos), .in_mts(in_mts), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_acc(out_acc), .out_ovf(out_ovf), .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  int last_acc, start_cyc;

  // Reference: exact integer sum with generous headroom.
  logic signed [W+15:0] m_sum, lim_hi, lim_lo;
  bit m_ovf;

  typedef struct packed {
    logic [6:0]       k;
    logic [3:0]       sg;
    logic [3:0]       zr;
    logic [3:0][6:0]  ps;
    logic [3:0][9:0]  mt;
    logic [W-1:0]     eacc;
    logic             eovf;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_add(input bit s, input bit z, input int p, input int m);
    logic signed [W+15:0] t;
    if (p > MAXPOS) m_ovf = 1'b1;
    else if (!z) begin
      t = '0;
      t[MW-1:0] = m[MW-1:0];
      t = t << p;
      if (s) t = -t;
      m_sum = m_sum + t;
      if (m_sum > lim_hi || m_sum < lim_lo) m_ovf = 1'b1;
    end
  endtask

  task automatic start_run(input int k);
    m_sum = '0; m_ovf = 1'b0;
    start = 1'b1; cfg_k = KW'(k); start_cyc = cyc;
    @(posedge clk_i); #1;
    start = 1'b0;
  endtask

  task automatic send_term(input bit s, input bit z, input int p, input int m);
    bit got = 1'b0;
    in_vld = 1'b1; in_sign = s; in_zero = z; in_pos = POSW'(p); in_mts = MW'(m);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      if (in_rdy) begin got = 1'b1; last_acc = cyc; break; end
    end
    chk("term_accept", got, 1'b1);
    if (got) model_add(s, z, p, m);
    @(posedge clk_i); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_out(output int vc);
    vc = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (out_vld) begin vc = cyc; break; end
    end
    chk("out_vld_seen", (vc >= 0), 1'b1);
  endtask

  task automatic handshake();
    out_rdy = 1'b1;
    @(posedge clk_i); #1;
    out_rdy = 1'b0;
    @(negedge clk_i);
    chk("out_vld_drop", out_vld, 1'b0);
    chk("busy_idle", busy, 1'b0);
  endtask

  task automatic expect_out(input string nm, input logic [W-1:0] eacc, input bit eovf, input int ecyc);
    int vc;
    wait_out(vc);
    chk({nm, "_acc"}, out_acc, eacc);
    chk({nm, "_ovf"}, out_ovf, eovf);
    if (ecyc >= 0) chk({nm, "_lat"}, vc, ecyc);
    handshake();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc;
    logic [W-1:0] ehold;
    lim_hi = '0; lim_hi[W-1] = 1'b1; lim_hi = lim_hi - 1; lim_lo = -lim_hi - 1;

    // Directed vectors.
    for (int i = 0; i < 6; i++) tbl[i] = '0;
    tbl[0].k = 3; tbl[0].sg = 4'b0100; tbl[0].mt[0] = 1023; tbl[0].mt[1] = 1; tbl[0].mt[2] = 1;
    tbl[0].eacc = W'(1023);
    tbl[1].k = 2; tbl[1].ps[0] = 14; tbl[1].ps[1] = 14; tbl[1].mt[0] = 1023; tbl[1].mt[1] = 1023;
    tbl[1].eacc = W'(2046) << 14;
    tbl[2].k = 1; tbl[2].sg = 4'b0001; tbl[2].mt[0] = 1; tbl[2].eacc = '1;
    tbl[3].k = 2; tbl[3].ps[0] = 7'(W - MW); tbl[3].mt[0] = 5; tbl[3].mt[1] = 3;
    tbl[3].eacc = W'(3); tbl[3].eovf = 1'b1;
    tbl[4].k = 4; tbl[4].sg = 4'b0010; tbl[4].zr = 4'b0100;
    tbl[4].ps[0] = 24; tbl[4].mt[0] = 100; tbl[4].mt[1] = 1;
    tbl[4].ps[2] = 5; tbl[4].mt[2] = 55; tbl[4].ps[3] = 48; tbl[4].mt[3] = 1;
    tbl[4].eacc = (W'(100) << 24) - W'(1) + (W'(1) << 48);
    tbl[5].k = 3; tbl[5].sg = 4'b0101;
    tbl[5].ps[0] = 91; tbl[5].mt[0] = 1023; tbl[5].ps[1] = 91; tbl[5].mt[1] = 1023;
    tbl[5].ps[2] = 90; tbl[5].mt[2] = 2;
    tbl[5].eacc = {W{1'b0}} - (W'(1) << 91);

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_in_rdy", in_rdy, 1'b0);
    chk("rst_out_vld", out_vld, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_acc", out_acc, '0);
    chk("rst_ovf", out_ovf, 1'b0);
    rstn = 1'b1;
    @(posedge clk_i); #1;

    for (int i = 0; i < 6; i++) begin
      start_run(int'(tbl[i].k));
      for (int j = 0; j < int'(tbl[i].k); j++)
        send_term(tbl[i].sg[j], tbl[i].zr[j], int'(tbl[i].ps[j]), int'(tbl[i].mt[j]));
      expect_out($sformatf("vec%0d", i), tbl[i].eacc, tbl[i].eovf, last_acc + NSEG + 1);
    end

    // Head overflow: 33 large positive terms.
    start_run(33);
    for (int j = 0; j < 33; j++) send_term(1'b0, 1'b0, MAXPOS, 1023);
    expect_out("head_ovf", m_sum[W-1:0], 1'b1, last_acc + NSEG + 1);

    // Output held while out_rdy low; offered terms are not taken.
    start_run(2);
    send_term(1'b0, 1'b0, 0, 3);
    send_term(1'b0, 1'b0, 1, 4);
    wait_out(vc);
    ehold = W'(11);
    in_vld = 1'b1; in_sign = 1'b0; in_zero = 1'b0; in_pos = '0; in_mts = MW'(1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk_i);
      chk("hold_acc", out_acc, ehold);
      chk("hold_in_rdy", in_rdy, 1'b0);
      chk("hold_out_vld", out_vld, 1'b1);
    end
    in_vld = 1'b0;
    handshake();

    // Start during ACC is ignored.
    start_run(2);
    send_term(1'b0, 1'b0, 0, 5);
    start = 1'b1; cfg_k = KW'(1);
    @(posedge clk_i); #1;
    start = 1'b0;
    send_term(1'b0, 1'b0, 0, 6);
    expect_out("start_ign", W'(11), 1'b0, last_acc + NSEG + 1);

    // Empty run.
    start_run(0);
    expect_out("k0", '0, 1'b0, start_cyc + NSEG + 1);

    // Oversized k saturates to KMAX.
    start_run(KMAX + 5);
    for (int j = 0; j < KMAX; j++) send_term(1'b0, 1'b0, 0, 1);
    expect_out("ksat", W'(KMAX), 1'b0, last_acc + NSEG + 1);

    // Reset mid-run after 2 of 4 terms (one out of range, so ovf is set).
    start_run(4);
    send_term(1'b0, 1'b0, 100, 9);
    send_term(1'b0, 1'b0, 0, 9);
    @(negedge clk_i);
    rstn = 1'b0;
    #1;
    chk("mrst_in_rdy", in_rdy, 1'b0);
    chk("mrst_out_vld", out_vld, 1'b0);
    chk("mrst_busy", busy, 1'b0);
    chk("mrst_acc", out_acc, '0);
    chk("mrst_ovf", out_ovf, 1'b0);
    @(posedge clk_i); #1;
    rstn = 1'b1;
    @(posedge clk_i); #1;
    start_run(1);
    send_term(1'b0, 1'b0, 3, 7);
    expect_out("post_rst", W'(56), 1'b0, last_acc + NSEG + 1);

    // Random runs against the exact-sum model.
    for (int r = 0; r < 20; r++) begin
      int k;
      k = $urandom_range(1, KMAX);
      start_run(k);
      for (int j = 0; j < k; j++) begin
        int p;
        bit s, z;
        if ($urandom_range(0, 3) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk_i);
          #1;
        end
        s = 1'($urandom_range(0, 1));
        z = ($urandom_range(0, 15) == 0);
        p = ($urandom_range(0, 29) == 0) ? $urandom_range(MAXPOS + 1, 127) : $urandom_range(0, 80);
        send_term(s, z, p, $urandom_range(0, 1023));
      end
      expect_out($sformatf("rnd%0d", r), m_sum[W-1:0], m_ovf, last_acc + NSEG + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
